// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA timing generator.
// Recovers pixel coordinates from a blank/sync stream, decides whether the
// frame geometry is valid (locked), and on request writes exactly one full
// frame into a frame buffer through a registered write port.
module vga_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic              vclock,
  input  logic              reset_n,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic [23:0]       rgb,
  input  logic              capture_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              locked
);

  localparam int unsigned GW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0]  CNT_MAX  = 10'd1023;
  localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
  localparam logic [GW-1:0] LOCK_CNT = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // Input stage and second stage used for edge detection
  logic        s_hsync_q;
  logic        s_vsync_q;
  logic        s_blank_q;
  logic [23:0] s_rgb_q;
  logic        d_vsync_q;
  logic        d_blank_q;

  // Edge events
  logic fs_s;
  logic le_s;
  logic vs_rise_s;

  // Geometry tracking
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       line_err_q, line_err_d;
  logic [9:0] y_end_s;
  logic       err_end_s;
  logic       good_s;

  // Lock tracking
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          seen_fs_q, seen_fs_d;
  logic          locked_q, locked_d;

  // Capture FSM and status outputs
  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   frame_done_q, frame_done_d;
  logic   frame_ok_q, frame_ok_d;

  // Write pipeline
  logic              pix_en_d;
  logic              pix_en_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [11:0]       pix_data_q;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [11:0]       wr_data_q;

  // Bits of the input stage that carry no information for this block
  logic unused_s;
  assign unused_s = ^{s_hsync_q, s_rgb_q[19:16], s_rgb_q[11:8], s_rgb_q[3:0]};

  // Frame start on falling vsync, line end on rising blank
  assign fs_s      = d_vsync_q & ~s_vsync_q;
  assign le_s      = s_blank_q & ~d_blank_q;
  assign vs_rise_s = s_vsync_q & ~d_vsync_q;

  // Register the raw inputs once, then keep a delayed copy for edges;
  // idle levels on reset so no edge is seen straight out of reset
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      s_hsync_q <= 1'b1;
      s_vsync_q <= 1'b1;
      s_blank_q <= 1'b1;
      s_rgb_q   <= 24'd0;
      d_vsync_q <= 1'b1;
      d_blank_q <= 1'b1;
    end else begin
      s_hsync_q <= hsync;
      s_vsync_q <= vsync;
      s_blank_q <= blank;
      s_rgb_q   <= rgb;
      d_vsync_q <= s_vsync_q;
      d_blank_q <= s_blank_q;
    end
  end

  // Line count and error flag as they stand once a coincident line end is folded in
  always_comb begin
    y_end_s   = y_q;
    err_end_s = line_err_q;
    if (le_s && (x_q != 10'd0)) begin
      if (y_q != CNT_MAX) begin
        y_end_s = y_q + 10'd1;
      end else begin
        y_end_s = y_q;
      end
      if (x_q != H_LIM) begin
        err_end_s = 1'b1;
      end else begin
        err_end_s = line_err_q;
      end
    end else begin
      y_end_s   = y_q;
      err_end_s = line_err_q;
    end
  end

  // The frame that ends at this fs is good only if a full frame was observed
  assign good_s = seen_fs_q & (y_end_s == V_LIM) & ~err_end_s;

  // Saturating pixel and line counters
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    line_err_d = line_err_q;
    if (fs_s) begin
      x_d        = 10'd0;
      y_d        = 10'd0;
      line_err_d = 1'b0;
    end else if (le_s) begin
      x_d        = 10'd0;
      y_d        = y_end_s;
      line_err_d = err_end_s;
    end else if (!s_blank_q && (x_q != CNT_MAX)) begin
      x_d = x_q + 10'd1;
    end else begin
      x_d = x_q;
    end
  end

  // Counter state
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      line_err_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      line_err_q <= line_err_d;
    end
  end

  // Good-frame counter: saturate on good frames, clear on any bad frame
  always_comb begin
    good_cnt_d = good_cnt_q;
    seen_fs_d  = seen_fs_q;
    if (fs_s) begin
      seen_fs_d = 1'b1;
      if (good_s) begin
        if (good_cnt_q != LOCK_CNT) begin
          good_cnt_d = good_cnt_q + GW'(1);
        end else begin
          good_cnt_d = good_cnt_q;
        end
      end else begin
        good_cnt_d = '0;
      end
    end else begin
      good_cnt_d = good_cnt_q;
    end
    locked_d = (good_cnt_d == LOCK_CNT);
  end

  // Lock state
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt_q <= '0;
      seen_fs_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      good_cnt_q <= good_cnt_d;
      seen_fs_q  <= seen_fs_d;
      locked_q   <= locked_d;
    end
  end

  // FSM state register
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: arm only while locked, capture the frame after arming
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_req && locked_q) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (fs_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (fs_s) begin
          state_d = ST_IDLE;
        end else if (vs_rise_s && !locked_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: completion/abort status, busy, and per-pixel write decision
  always_comb begin
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    if ((state_q == ST_CAPTURE) && fs_s) begin
      frame_done_d = 1'b1;
      frame_ok_d   = good_s;
    end else if ((state_q == ST_CAPTURE) && vs_rise_s && !locked_q) begin
      frame_done_d = 1'b1;
      frame_ok_d   = 1'b0;
    end else begin
      frame_done_d = 1'b0;
    end
    busy_d   = (state_d != ST_IDLE);
    pix_en_d = (state_q == ST_CAPTURE) && !s_blank_q && (x_q < H_LIM) && (y_q < V_LIM);
  end

  // Status registers
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
    end
  end

  // Running write address: restarts each frame, advances per written pixel
  always_comb begin
    addr_cnt_d = addr_cnt_q;
    if (fs_s) begin
      addr_cnt_d = '0;
    end else if (pix_en_d) begin
      addr_cnt_d = addr_cnt_q + ADDR_W'(1);
    end else begin
      addr_cnt_d = addr_cnt_q;
    end
  end

  // Two-stage write pipeline so outputs trail the sampled pixel by two edges
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt_q <= '0;
      pix_en_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= 12'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 12'd0;
    end else begin
      addr_cnt_q <= addr_cnt_d;
      pix_en_q   <= pix_en_d;
      pix_addr_q <= addr_cnt_q;
      pix_data_q <= {s_rgb_q[23:20], s_rgb_q[15:12], s_rgb_q[7:4]};
      wr_en_q    <= pix_en_q;
      if (pix_en_q) begin
        wr_addr_q <= pix_addr_q;
        wr_data_q <= pix_data_q;
      end else begin
        wr_addr_q <= wr_addr_q;
        wr_data_q <= wr_data_q;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign locked     = locked_q;

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
Receive-side counterpart of the VGA timing generator. Consumes a 640x480 hsync/vsync/blank/rgb pixel stream (active-low syncs), recovers pixel coordinates, and checks that the frame geometry is valid. On request, it writes exactly one complete frame into a frame buffer through a simple write port. Used to loop back the generator output for self-test and to capture external VGA-timed sources.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
LOCK_FRAMES, 2, consecutive good frames required before locked asserts
ADDR_W, 19, frame-buffer address width (must hold H_ACTIVE*V_ACTIVE)

Ports:
vclock  in  1  pixel clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync, active low
vsync  in  1  vertical sync, active low
blank  in  1  high outside the active region
rgb  in  24  pixel {R[7:0],G[7:0],B[7:0]}, valid when blank=0
capture_req  in  1  single-cycle request to capture the next full frame
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  linear address y*H_ACTIVE+x
wr_data  out  12  {R[7:4],G[7:4],B[7:4]}
busy  out  1  high in ARMED or CAPTURE
frame_done  out  1  one-cycle pulse when a capture ends
frame_ok  out  1  result of the last capture; held until the next frame_done
locked  out  1  input geometry is stable and valid

Behaviour:
- Reset: async on reset_n=0. All outputs go to 0, FSM to IDLE, counters and the good-frame count to 0.
- Input stage: hsync, vsync, blank and rgb are registered once (s_*). Edge detection compares s_* to a second register stage.
- Frame start (fs): falling edge of s_vsync. Line end (le): rising edge of s_blank.
- Pixel counter x: increments on each cycle with s_blank=0. Cleared at le and at fs.
- Line counter y: at le with x!=0, y increments; if x!=H_ACTIVE, line_err sets. y is cleared at fs. Counters saturate at their max (x at 1023, y at 1023) and do not wrap.
- Frame check at each fs, for the frame just ended: good = (y==V_ACTIVE) & ~line_err. line_err is then cleared.
- Good-frame count: on a good frame it increments, saturating at LOCK_FRAMES. On a bad frame it clears to 0.
- locked = (good-frame count == LOCK_FRAMES), registered. It deasserts in the cycle after the fs that ends a bad frame.
- The first fs after reset ends a partial frame, which is always bad.
- FSM states: IDLE, ARMED, CAPTURE.
  - IDLE -> ARMED: capture_req=1 and locked=1. A request while unlocked is dropped.
  - ARMED -> CAPTURE: on the next fs.
  - CAPTURE -> IDLE: on the next fs. frame_done pulses and frame_ok = good for that frame.
  - CAPTURE -> IDLE early: if s_vsync rises and locked falls, frame_done pulses with frame_ok=0 (abort).
  - capture_req in ARMED or CAPTURE is ignored.
  - fs coincident with capture_req in IDLE: go to ARMED only; capture starts at the following fs.
- Write port (CAPTURE only):
  - wr_en=1 for a pixel when s_blank=0, x<H_ACTIVE and y<V_ACTIVE.
  - wr_addr is a running counter: cleared at fs, +1 per written pixel. It does not multiply.
  - wr_data is the truncated s_rgb.
  - Latency: rgb sampled at edge N produces wr_en/wr_addr/wr_data at edge N+2. These outputs are registered.
  - Pixels beyond H_ACTIVE or V_ACTIVE are not written; they flag an error through the check above.
- busy is high exactly while the FSM is in ARMED or CAPTURE.
- Good capture: exactly H_ACTIVE*V_ACTIVE = 307200 writes at addresses 0..307199, in order, with no gaps or repeats.

Test Plan:
1. Nominal loopback: drive 800x524 timing (hblank at 640, hsync 656-751, vsync lines 491-492, blank lines 480-523) with rgb = {x[7:0],y[7:0],8'h5A}. Required: locked=1 after the 3rd fs. After capture_req: 307200 wr_en pulses. Address 641 carries data {0x0,0x0,0x5} for pixel (1,1). frame_done pulses once with frame_ok=1.
2. Short line: line 100 has 639 active pixels. Required: the next fs drops locked to 0. An in-flight capture ends with frame_ok=0. Relock occurs after 2 clean frames.
3. Wrong line count: a frame with 479 active lines. Required: locked falls; capture_req issued while unlocked yields busy=0 and no writes.
4. Request timing: capture_req asserted on the same cycle as fs while in IDLE. Required: busy=1, no writes during that frame, and writing starts at the following frame with wr_addr=0.
5. Reset mid-capture: reset_n low for 3 cycles at pixel (320,240). Required: all outputs 0 immediately (asynchronous). After release: locked=0 until 2 good frames after the first partial frame, and no further writes without a new capture_req.
6. Back-to-back requests: capture_req again during CAPTURE. Required: ignored, exactly one frame_done; a request after frame_done captures the next full frame.
